risc8_pin_change: RTL and testbench

- Input-direction companion to the SoC's port_b output path.
- Takes the asynchronous pin_b pins from off-chip and synchronizes them, with optional debouncing.
- Exposes the synchronized value, a per-pin change mask and write-1-to-clear change flags on the risc8 I/O register bus.
- Raises a level interrupt to the CPU while any enabled flag is pending.

---
 rtl/risc8_io_defs.sv | 24 ++
 rtl/risc8_debounce_bit.sv | 52 +++++
 rtl/risc8_pin_change.sv | 109 ++++++++++
 tb/tb_risc8_pin_change.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/risc8_io_defs.sv
// Shared risc8 I/O register bus definitions: address width, default register
// addresses and the request payload seen by peripheral blocks.
package risc8_io_defs;

    localparam int unsigned IO_ADDR_W = 6;
    localparam int unsigned IO_DATA_W = 8;

    localparam logic [IO_ADDR_W-1:0] ADDR_PIN_DEF = 6'h16;
    localparam logic [IO_ADDR_W-1:0] ADDR_MSK_DEF = 6'h17;
    localparam logic [IO_ADDR_W-1:0] ADDR_FLG_DEF = 6'h18;

    typedef struct packed {
        logic [IO_ADDR_W-1:0] addr;
        logic [IO_DATA_W-1:0] wdata;
        logic                 we;
        logic                 re;
    } io_req_t;

    // True when the request is a write strobe aimed at the given address.
    function automatic logic io_write_hit(input io_req_t req, input logic [IO_ADDR_W-1:0] addr);
        return req.we && (req.addr == addr);
    endfunction

endpackage

// File: rtl/risc8_debounce_bit.sv
// One input pin: two-flop synchronizer followed by an optional tick-sampled
// debouncer that accepts a new level after COUNT consecutive differing ticks.
module risc8_debounce_bit #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned COUNT  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic tick,
    output logic level
);

    localparam int unsigned CNT_W = 4;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronizer stages carry no logic between them.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // In bypass mode tick is held low by the parent, so cnt stays at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (BYPASS) begin
            level <= sync2;
        end else if (tick) begin
            if (sync2 != level) begin
                if (cnt == CNT_W'(COUNT - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/risc8_pin_change.sv
// Pin-change block for the risc8 port_b input side: synchronized/debounced PIN
// value, change MASK, write-1-to-clear FLAG register and a level interrupt.
module risc8_pin_change
    import risc8_io_defs::*;
#(
    parameter int unsigned          WIDTH          = 8,
    parameter logic [IO_ADDR_W-1:0] ADDR_PIN       = ADDR_PIN_DEF,
    parameter logic [IO_ADDR_W-1:0] ADDR_MSK       = ADDR_MSK_DEF,
    parameter logic [IO_ADDR_W-1:0] ADDR_FLG       = ADDR_FLG_DEF,
    parameter int unsigned          DEBOUNCE_DIV   = 0,
    parameter int unsigned          DEBOUNCE_COUNT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     pin_in,
    input  logic [WIDTH-1:0]     ddr,
    input  logic [IO_ADDR_W-1:0] io_addr,
    input  logic [IO_DATA_W-1:0] io_wdata,
    input  logic                 io_we,
    input  logic                 io_re,
    output logic [IO_DATA_W-1:0] io_rdata,
    output logic                 irq
);

    localparam int unsigned PRE_W  = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam bit          BYPASS = (DEBOUNCE_DIV == 0);

    io_req_t              req;
    logic [PRE_W-1:0]     presc;
    logic                 tick_c;
    logic [WIDTH-1:0]     deb;
    logic [WIDTH-1:0]     deb_prev;
    logic [WIDTH-1:0]     msk;
    logic [WIDTH-1:0]     flg;
    logic [WIDTH-1:0]     chg_c;
    logic [WIDTH-1:0]     clr_c;
    logic [WIDTH-1:0]     flg_next_c;
    logic [IO_DATA_W-1:0] rd_c;

    assign req = '{addr: io_addr, wdata: io_wdata, we: io_we, re: io_re};

    // Shared debounce sample tick, asserted on the prescaler wrap cycle.
    assign tick_c = !BYPASS && (presc == PRE_W'(DEBOUNCE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || BYPASS) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        risc8_debounce_bit #(
            .BYPASS (BYPASS),
            .COUNT  (DEBOUNCE_COUNT)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .pin   (pin_in[i]),
            .tick  (tick_c),
            .level (deb[i])
        );
    end

    // Only a debounced transition on an enabled input pin raises a flag.
    assign chg_c      = (deb ^ deb_prev) & msk & ~ddr;
    assign clr_c      = io_write_hit(req, ADDR_FLG) ? req.wdata[WIDTH-1:0] : '0;
    assign flg_next_c = (flg & ~clr_c) | chg_c;

    always_comb begin
        rd_c = '0;
        if (req.addr == ADDR_PIN) begin
            rd_c = IO_DATA_W'(deb);
        end else if (req.addr == ADDR_MSK) begin
            rd_c = IO_DATA_W'(msk);
        end else if (req.addr == ADDR_FLG) begin
            rd_c = IO_DATA_W'(flg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev <= '0;
            msk      <= '0;
            flg      <= '0;
            irq      <= 1'b0;
        end else begin
            deb_prev <= deb;
            flg      <= flg_next_c;
            irq      <= |flg_next_c;
            if (io_write_hit(req, ADDR_MSK)) begin
                msk <= req.wdata[WIDTH-1:0];
            end
        end
    end

    // Read data reflects register contents before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_rdata <= '0;
        end else if (req.re) begin
            io_rdata <= rd_c;
        end
    end

endmodule

// File: tb/tb_risc8_pin_change.sv
// Bench for risc8_pin_change: a bypass instance driven by a vector table and a
// debounced instance (DIV=4, COUNT=3) exercised by hand-written sequences.
module tb_risc8_pin_change;

    localparam logic [5:0] A_PIN = 6'h16;
    localparam logic [5:0] A_MSK = 6'h17;
    localparam logic [5:0] A_FLG = 6'h18;
    localparam logic [5:0] A_BAD = 6'h20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pin_in;
    logic [7:0] ddr;
    logic [5:0] io_addr;
    logic [7:0] io_wdata;
    logic       io_we;
    logic       io_re;
    logic [7:0] rdata0;
    logic       irq0;
    logic [7:0] rdata1;
    logic       irq1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] pin;
        logic [7:0] ddr;
        logic       we;
        logic       re;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         idle;
        logic [7:0] exp_rdata;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    risc8_pin_change dut (
        .clk(clk), .reset(reset), .pin_in(pin_in), .ddr(ddr),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
        .io_rdata(rdata0), .irq(irq0)
    );

    risc8_pin_change #(.DEBOUNCE_DIV(4), .DEBOUNCE_COUNT(3)) dut_db (
        .clk(clk), .reset(reset), .pin_in(pin_in), .ddr(ddr),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
        .io_rdata(rdata1), .irq(irq1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic re, input logic [5:0] addr, input logic [7:0] wdata);
        io_we    = we;
        io_re    = re;
        io_addr  = addr;
        io_wdata = wdata;
        step();
        io_we = 1'b0;
        io_re = 1'b0;
    endtask

    task automatic add(input logic [7:0] pin, input logic [7:0] d, input logic we, input logic re,
                       input logic [5:0] addr, input logic [7:0] wdata, input int idle,
                       input logic [7:0] exp_rdata, input logic exp_irq);
        vec_t v;
        v = '{pin, d, we, re, addr, wdata, idle, exp_rdata, exp_irq};
        vecs.push_back(v);
    endtask

    // Polls the debounced instance's PIN register; returns the first poll whose bit 5 reads 1.
    task automatic poll_pin5(input int first_k, input int last_k, output int found);
        found = 0;
        for (int k = first_k; k <= last_k; k++) begin
            bus(1'b0, 1'b1, A_PIN, 8'h00);
            if (found == 0 && rdata1[5]) found = k;
        end
    endtask

    initial begin
        int first;
        reset = 1'b1; pin_in = 8'hFF; ddr = 8'h00;
        io_addr = 6'h00; io_wdata = 8'h00; io_we = 1'b0; io_re = 1'b0;

        //            pin    ddr    we    re    addr   wdata idle rdata irq
        add(8'hFF, 8'h00, 1'b0, 1'b0, A_PIN, 8'h00, 2, 8'h00, 1'b0); // 0
        add(8'hFF, 8'h00, 1'b0, 1'b1, A_PIN, 8'h00, 0, 8'hFF, 1'b0); // 1
        add(8'hFF, 8'h00, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h00, 1'b0); // 2
        add(8'hFF, 8'h00, 1'b0, 1'b1, A_MSK, 8'h00, 0, 8'h00, 1'b0); // 3
        add(8'h00, 8'h00, 1'b0, 1'b0, A_MSK, 8'h00, 3, 8'h00, 1'b0); // 4
        add(8'h00, 8'h00, 1'b1, 1'b0, A_MSK, 8'h01, 0, 8'h00, 1'b0); // 5
        add(8'h00, 8'h00, 1'b0, 1'b1, A_MSK, 8'h00, 0, 8'h01, 1'b0); // 6
        add(8'h01, 8'h00, 1'b0, 1'b0, A_MSK, 8'h00, 2, 8'h01, 1'b0); // 7: 3rd edge, no irq yet
        add(8'h01, 8'h00, 1'b0, 1'b0, A_MSK, 8'h00, 0, 8'h01, 1'b1); // 8: 4th edge, irq
        add(8'h01, 8'h00, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h01, 1'b1); // 9
        add(8'h01, 8'h00, 1'b1, 1'b0, A_FLG, 8'h01, 0, 8'h01, 1'b0); // 10
        add(8'h01, 8'h00, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h00, 1'b0); // 11
        add(8'h01, 8'h00, 1'b1, 1'b1, A_MSK, 8'h0F, 0, 8'h01, 1'b0); // 12: read returns pre-write
        add(8'h01, 8'h03, 1'b0, 1'b1, A_MSK, 8'h00, 0, 8'h0F, 1'b0); // 13
        add(8'h0E, 8'h03, 1'b0, 1'b0, A_MSK, 8'h00, 3, 8'h0F, 1'b1); // 14
        add(8'h0E, 8'h03, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h0C, 1'b1); // 15: ddr pins excluded
        add(8'h0E, 8'h03, 1'b1, 1'b0, A_FLG, 8'hFF, 0, 8'h0C, 1'b0); // 16
        add(8'h0E, 8'h03, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h00, 1'b0); // 17
        add(8'h0A, 8'h03, 1'b0, 1'b0, A_FLG, 8'h00, 2, 8'h00, 1'b0); // 18
        add(8'h0A, 8'h03, 1'b1, 1'b0, A_FLG, 8'h04, 0, 8'h00, 1'b1); // 19: set beats clear
        add(8'h0A, 8'h03, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h04, 1'b1); // 20
        add(8'h0A, 8'h03, 1'b1, 1'b0, A_FLG, 8'h04, 0, 8'h04, 1'b0); // 21
        add(8'h0A, 8'h00, 1'b1, 1'b0, A_MSK, 8'hFF, 0, 8'h04, 1'b0); // 22
        add(8'h0A, 8'h00, 1'b0, 1'b0, A_MSK, 8'h00, 3, 8'h04, 1'b0); // 23: ddr/mask change alone
        add(8'h0A, 8'h00, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h00, 1'b0); // 24
        add(8'h0A, 8'h00, 1'b1, 1'b0, A_PIN, 8'h55, 0, 8'h00, 1'b0); // 25: PIN write ignored
        add(8'h0A, 8'h00, 1'b0, 1'b1, A_PIN, 8'h00, 0, 8'h0A, 1'b0); // 26
        add(8'h0A, 8'h00, 1'b0, 1'b1, A_BAD, 8'h00, 0, 8'h00, 1'b0); // 27
        add(8'h0B, 8'h00, 1'b0, 1'b0, A_BAD, 8'h00, 3, 8'h00, 1'b1); // 28: rising edge
        add(8'h0A, 8'h00, 1'b0, 1'b0, A_BAD, 8'h00, 3, 8'h00, 1'b1); // 29: falling edge
        add(8'h0A, 8'h00, 1'b0, 1'b1, A_FLG, 8'h00, 0, 8'h01, 1'b1); // 30: still just 1
        add(8'h0A, 8'h00, 1'b1, 1'b0, A_FLG, 8'h01, 0, 8'h01, 1'b0); // 31

        // Reset held with pins high.
        repeat (4) step();
        check("reset_rdata", rdata0, 8'h00);
        check("reset_irq", {7'b0, irq0}, 8'h00);
        check("reset_rdata_db", rdata1, 8'h00);
        check("reset_irq_db", {7'b0, irq1}, 8'h00);
        reset = 1'b0;

        foreach (vecs[i]) begin
            pin_in = vecs[i].pin;
            ddr    = vecs[i].ddr;
            bus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            repeat (vecs[i].idle) step();
            check($sformatf("vec%0d_rdata", i), rdata0, vecs[i].exp_rdata);
            check($sformatf("vec%0d_irq", i), {7'b0, irq0}, {7'b0, vecs[i].exp_irq});
        end

        // Debounced instance: short glitch must be rejected.
        reset = 1'b1; pin_in = 8'h00; ddr = 8'h00;
        repeat (2) step();
        reset = 1'b0;
        bus(1'b1, 1'b0, A_MSK, 8'h20);
        pin_in = 8'h20;
        repeat (5) step();
        pin_in = 8'h00;
        repeat (12) step();
        bus(1'b0, 1'b1, A_PIN, 8'h00);
        check("db_glitch_pin", rdata1, 8'h00);
        check("db_glitch_irq", {7'b0, irq1}, 8'h00);
        bus(1'b0, 1'b1, A_FLG, 8'h00);
        check("db_glitch_flg", rdata1, 8'h00);

        // Held level is accepted after three ticks.
        pin_in = 8'h20;
        poll_pin5(1, 30, first);
        if (first < 12 || first > 16) begin
            failures++;
            $display("FAIL db_hold_latency actual=%0d expected=12..16", first);
        end
        checks++;
        check("db_hold_irq", {7'b0, irq1}, 8'h01);
        bus(1'b0, 1'b1, A_FLG, 8'h00);
        check("db_hold_flg", rdata1, 8'h20);

        // Reset two ticks into a change discards the partial count.
        reset = 1'b1;
        repeat (2) step();
        check("db_reset_rdata", rdata1, 8'h00);
        check("db_reset_irq", {7'b0, irq1}, 8'h00);
        reset = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus(1'b0, 1'b1, A_PIN, 8'h00);
        check("db_rst_pin", rdata1, 8'h00);
        bus(1'b0, 1'b1, A_MSK, 8'h00);
        check("db_rst_msk", rdata1, 8'h00);
        bus(1'b0, 1'b1, A_FLG, 8'h00);
        check("db_rst_flg", rdata1, 8'h00);
        check("db_rst_irq", {7'b0, irq1}, 8'h00);
        poll_pin5(4, 20, first);
        check("db_rst_relatency", 8'(first), 8'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
